// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline widths, PC index and forward-select encoding
package cpu_pipe_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  function automatic logic [1:0] max2(input logic [1:0] x, input logic [1:0] y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass select, data mux and stall-need report
module fwd_mux
  import cpu_pipe_pkg::*;
(
  input  logic              byp_en,
  input  logic              use_op,
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] port,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_rfld,
  input  logic              ex_load,
  input  logic [DATA_W-1:0] ex_res,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              mem_rfld,
  input  logic [DATA_W-1:0] mem_res,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              wb_rfld,
  input  logic [DATA_W-1:0] wb_res,
  output logic [1:0]        need,
  output logic [DATA_W-1:0] data
);

  logic     src_ok;
  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;
  fwd_sel_t sel;

  // The PC index is read straight from the port and never takes part in matching.
  assign src_ok  = use_op && (src != REG_PC);
  assign ex_hit  = src_ok && ex_rfld  && (ex_rd  == src);
  assign mem_hit = src_ok && mem_rfld && (mem_rd == src);
  assign wb_hit  = src_ok && wb_rfld  && (wb_rd  == src);

  always_comb begin
    sel  = FWD_RF;
    need = 2'd0;
    data = port;
    if (byp_en) begin
      if (ex_hit && !ex_load) sel = FWD_EX;
      else if (mem_hit)       sel = FWD_MEM;
      else if (wb_hit)        sel = FWD_WB;
      if (ex_hit && ex_load)  need = 2'd1;
    end else begin
      // Without bypass the stall must cover every stage still ahead of the writer.
      if (ex_hit)       need = 2'd3;
      else if (mem_hit) need = 2'd2;
      else if (wb_hit)  need = 2'd1;
    end
    case (sel)
      FWD_EX:  data = ex_res;
      FWD_MEM: data = mem_res;
      FWD_WB:  data = wb_res;
      default: data = port;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and stall control (ID_EX_FWD_EN enables bypass)
module id_ex_stage
  import cpu_pipe_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] PA,
  input  logic [DATA_W-1:0] PB,
  input  logic [DATA_W-1:0] PD,
  input  logic [REG_W-1:0]  SA,
  input  logic [REG_W-1:0]  SB,
  input  logic [REG_W-1:0]  SD,
  input  logic              USE_A,
  input  logic              USE_B,
  input  logic              USE_D,
  input  logic [REG_W-1:0]  RD_ID,
  input  logic              RFLD_ID,
  input  logic              MEMRD_ID,
  input  logic              VALID_ID,
  input  logic [DATA_W-1:0] EX_RES,
  input  logic [DATA_W-1:0] MEM_RES,
  input  logic [DATA_W-1:0] WB_RES,
  input  logic [REG_W-1:0]  MEM_RD,
  input  logic [REG_W-1:0]  WB_RD,
  input  logic              MEM_RFLD,
  input  logic              WB_RFLD,
  output logic [DATA_W-1:0] A_EX,
  output logic [DATA_W-1:0] B_EX,
  output logic [DATA_W-1:0] D_EX,
  output logic [REG_W-1:0]  RD_EX,
  output logic              RFLD_EX,
  output logic              MEMRD_EX,
  output logic              VALID_EX,
  output logic              HZPCLD,
  output logic              IFID_LD
);

`ifdef ID_EX_FWD_EN
  localparam logic BYP_EN = 1'b1;
`else
  localparam logic BYP_EN = 1'b0;
`endif

  logic [DATA_W-1:0] a_fwd;
  logic [DATA_W-1:0] b_fwd;
  logic [DATA_W-1:0] d_fwd;
  logic [1:0]        need_a;
  logic [1:0]        need_b;
  logic [1:0]        need_d;
  logic [1:0]        need;
  logic [1:0]        eff;
  logic [1:0]        stall_cnt;
  logic [1:0]        cnt_next;
  logic              stall;

  fwd_mux u_fwd_a (
    .byp_en(BYP_EN), .use_op(USE_A), .src(SA), .port(PA),
    .ex_rd(RD_EX), .ex_rfld(RFLD_EX), .ex_load(MEMRD_EX), .ex_res(EX_RES),
    .mem_rd(MEM_RD), .mem_rfld(MEM_RFLD), .mem_res(MEM_RES),
    .wb_rd(WB_RD), .wb_rfld(WB_RFLD), .wb_res(WB_RES),
    .need(need_a), .data(a_fwd)
  );

  fwd_mux u_fwd_b (
    .byp_en(BYP_EN), .use_op(USE_B), .src(SB), .port(PB),
    .ex_rd(RD_EX), .ex_rfld(RFLD_EX), .ex_load(MEMRD_EX), .ex_res(EX_RES),
    .mem_rd(MEM_RD), .mem_rfld(MEM_RFLD), .mem_res(MEM_RES),
    .wb_rd(WB_RD), .wb_rfld(WB_RFLD), .wb_res(WB_RES),
    .need(need_b), .data(b_fwd)
  );

  fwd_mux u_fwd_d (
    .byp_en(BYP_EN), .use_op(USE_D), .src(SD), .port(PD),
    .ex_rd(RD_EX), .ex_rfld(RFLD_EX), .ex_load(MEMRD_EX), .ex_res(EX_RES),
    .mem_rd(MEM_RD), .mem_rfld(MEM_RFLD), .mem_res(MEM_RES),
    .wb_rd(WB_RD), .wb_rfld(WB_RFLD), .wb_res(WB_RES),
    .need(need_d), .data(d_fwd)
  );

  // A running countdown wins over a fresh match unless the match needs longer.
  always_comb begin
    need     = VALID_ID ? max2(need_a, max2(need_b, need_d)) : 2'd0;
    eff      = max2(stall_cnt, need);
    stall    = (eff != 2'd0);
    cnt_next = stall ? (eff - 2'd1) : 2'd0;
    HZPCLD   = RST || !stall;
    IFID_LD  = RST || !stall;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A_EX      <= '0;
      B_EX      <= '0;
      D_EX      <= '0;
      RD_EX     <= '0;
      RFLD_EX   <= 1'b0;
      MEMRD_EX  <= 1'b0;
      VALID_EX  <= 1'b0;
      stall_cnt <= 2'd0;
    end else begin
      stall_cnt <= cnt_next;
      if (stall) begin
        A_EX     <= '0;
        B_EX     <= '0;
        D_EX     <= '0;
        RD_EX    <= '0;
        RFLD_EX  <= 1'b0;
        MEMRD_EX <= 1'b0;
        VALID_EX <= 1'b0;
      end else begin
        A_EX     <= a_fwd;
        B_EX     <= b_fwd;
        D_EX     <= d_fwd;
        RD_EX    <= RD_ID;
        RFLD_EX  <= RFLD_ID;
        MEMRD_EX <= MEMRD_ID;
        VALID_EX <= VALID_ID;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a reference model
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pa, pb, pd;
  logic [3:0]  sa, sb, sd;
  logic        use_a, use_b, use_d;
  logic [3:0]  rd_id;
  logic        rfld_id, memrd_id, valid_id;
  logic [31:0] ex_res, mem_res, wb_res;
  logic [3:0]  mem_rd, wb_rd;
  logic        mem_rfld, wb_rfld;
  logic [31:0] a_ex, b_ex, d_ex;
  logic [3:0]  rd_ex;
  logic        rfld_ex, memrd_ex, valid_ex;
  logic        hzpcld, ifid_ld;

  int checks;
  int failures;

  // reference model of the EX register contents and outstanding stall cycles
  logic [3:0]  m_rd;
  logic        m_rfld, m_memrd, m_valid;
  int          rem;

  id_ex_stage dut (
    .CLK(clk), .RST(rst),
    .PA(pa), .PB(pb), .PD(pd), .SA(sa), .SB(sb), .SD(sd),
    .USE_A(use_a), .USE_B(use_b), .USE_D(use_d),
    .RD_ID(rd_id), .RFLD_ID(rfld_id), .MEMRD_ID(memrd_id), .VALID_ID(valid_id),
    .EX_RES(ex_res), .MEM_RES(mem_res), .WB_RES(wb_res),
    .MEM_RD(mem_rd), .WB_RD(wb_rd), .MEM_RFLD(mem_rfld), .WB_RFLD(wb_rfld),
    .A_EX(a_ex), .B_EX(b_ex), .D_EX(d_ex), .RD_EX(rd_ex),
    .RFLD_EX(rfld_ex), .MEMRD_EX(memrd_ex), .VALID_EX(valid_ex),
    .HZPCLD(hzpcld), .IFID_LD(ifid_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pa = 0; pb = 0; pd = 0; sa = 0; sb = 0; sd = 0;
    use_a = 0; use_b = 0; use_d = 0;
    rd_id = 0; rfld_id = 0; memrd_id = 0; valid_id = 1;
    ex_res = 0; mem_res = 0; wb_res = 0;
    mem_rd = 0; wb_rd = 0; mem_rfld = 0; wb_rfld = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_a"}, a_ex, 0);
    check({tag, "_b"}, b_ex, 0);
    check({tag, "_d"}, d_ex, 0);
    check({tag, "_rd"}, {28'd0, rd_ex}, 0);
    check({tag, "_rfld"}, {31'd0, rfld_ex}, 0);
    check({tag, "_memrd"}, {31'd0, memrd_ex}, 0);
    check({tag, "_valid"}, {31'd0, valid_ex}, 0);
  endtask

  task automatic check_ctl(input string tag, input logic exp);
    check({tag, "_hzpcld"}, {31'd0, hzpcld}, {31'd0, exp});
    check({tag, "_ifid_ld"}, {31'd0, ifid_ld}, {31'd0, exp});
  endtask

  // Operand value the EX stage must receive, from the forwarding rules.
  function automatic logic [31:0] model_val(input logic [3:0] s, input logic u, input logic [31:0] p);
    logic [31:0] v;
    v = p;
    if (FWD && u && s != 4'd15) begin
      if (m_rfld && !m_memrd && m_rd == s)  v = ex_res;
      else if (mem_rfld && mem_rd == s)     v = mem_res;
      else if (wb_rfld && wb_rd == s)       v = wb_res;
    end
    return v;
  endfunction

  // Stall cycles an operand needs, counted from the current cycle.
  function automatic int model_need(input logic [3:0] s, input logic u);
    if (!u || s == 4'd15) return 0;
    if (FWD) return (m_rfld && m_memrd && m_rd == s) ? 1 : 0;
    if (m_rfld && m_rd == s) return 3;
    if (mem_rfld && mem_rd == s) return 2;
    if (wb_rfld && wb_rd == s) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : r[3:0];
  endfunction

  task automatic rand_inputs();
    pa = $urandom; pb = $urandom; pd = $urandom;
    sa = pick_reg(); sb = pick_reg(); sd = pick_reg();
    use_a = $urandom_range(0, 1) == 1; use_b = $urandom_range(0, 1) == 1; use_d = $urandom_range(0, 1) == 1;
    rd_id = pick_reg(); rfld_id = $urandom_range(0, 1) == 1;
    memrd_id = $urandom_range(0, 2) == 0; valid_id = $urandom_range(0, 5) != 0;
    ex_res = $urandom; mem_res = $urandom; wb_res = $urandom;
    mem_rd = pick_reg(); wb_rd = pick_reg();
    mem_rfld = $urandom_range(0, 2) == 0; wb_rfld = $urandom_range(0, 2) == 0;
  endtask

  initial begin
    int eff;
    logic exp_stall;
    logic [31:0] ea, eb, ed;
    checks = 0;
    failures = 0;
    clear_inputs();
    rst = 1'b1;

    // reset with a pending match on the inputs must still hold PC load high
    sa = 4'd3; use_a = 1; pa = 32'h5555; mem_rd = 4'd3; mem_rfld = 1; wb_rd = 4'd3; wb_rfld = 1;
    tick();
    tick();
    check_regs_zero("reset");
    check_ctl("reset", 1'b1);
    clear_inputs();
    rst = 1'b0;

`ifdef ID_EX_FWD_EN
    rd_id = 4'd3; rfld_id = 1; pa = 32'h100; pb = 32'h200; pd = 32'h300;
    tick();
    check("cap_a", a_ex, 32'h100);
    check("cap_rd", {28'd0, rd_ex}, 3);

    clear_inputs();
    sa = 4'd3; use_a = 1; pa = 32'h0; ex_res = 32'h11; rd_id = 4'd5; rfld_id = 1; memrd_id = 1;
    #1 check_ctl("alu_raw", 1'b1);
    tick();
    check("alu_raw_a", a_ex, 32'h11);
    check("load_memrd", {31'd0, memrd_ex}, 1);

    clear_inputs();
    sb = 4'd5; use_b = 1; pb = 32'h77; rd_id = 4'd6; rfld_id = 1;
    #1 check_ctl("load_use", 1'b0);
    tick();
    check("bubble_valid", {31'd0, valid_ex}, 0);
    check("bubble_rfld", {31'd0, rfld_ex}, 0);
    check("bubble_rd", {28'd0, rd_ex}, 0);
    mem_rd = 4'd5; mem_rfld = 1; mem_res = 32'h2A;
    #1 check_ctl("load_use_release", 1'b1);
    tick();
    check("load_fwd_b", b_ex, 32'h2A);
    check("load_fwd_valid", {31'd0, valid_ex}, 1);

    clear_inputs();
    rd_id = 4'd2; rfld_id = 1;
    tick();
    clear_inputs();
    sa = 4'd2; use_a = 1; pa = 32'h99; ex_res = 32'h1; mem_rd = 4'd2; mem_rfld = 1; mem_res = 32'h2;
    wb_rd = 4'd2; wb_rfld = 1; wb_res = 32'h3; rd_id = 4'd15; rfld_id = 1;
    tick();
    check("priority_a", a_ex, 32'h1);

    clear_inputs();
    sa = 4'd15; use_a = 1; pa = 32'h40; ex_res = 32'hdead; rd_id = 4'd5; rfld_id = 1; memrd_id = 1;
    tick();
    check("pc_src_a", a_ex, 32'h40);

    clear_inputs();
    sd = 4'd5; use_d = 0; pd = 32'h1234; rd_id = 4'd7; rfld_id = 1; memrd_id = 1;
    #1 check_ctl("unused_op", 1'b1);
    tick();
    check("unused_d", d_ex, 32'h1234);

    clear_inputs();
    sa = 4'd7; use_a = 1;
    #1 check_ctl("pre_reset_stall", 1'b0);
`else
    rd_id = 4'd4; rfld_id = 1;
    tick();
    check("cap_rd", {28'd0, rd_ex}, 4);

    clear_inputs();
    sa = 4'd4; use_a = 1; pa = 32'h44; ex_res = 32'hEE; rd_id = 4'd9; rfld_id = 1;
    #1 check_ctl("nf_stall1", 1'b0);
    tick();
    check("nf_bubble_valid", {31'd0, valid_ex}, 0);
    check("nf_bubble_rd", {28'd0, rd_ex}, 0);
    mem_rd = 4'd4; mem_rfld = 1; mem_res = 32'hEE;
    #1 check_ctl("nf_stall2", 1'b0);
    tick();
    mem_rfld = 0; wb_rd = 4'd4; wb_rfld = 1; wb_res = 32'hEE;
    #1 check_ctl("nf_stall3", 1'b0);
    tick();
    wb_rfld = 0;
    #1 check_ctl("nf_release", 1'b1);
    tick();
    check("nf_a_from_rf", a_ex, 32'h44);
    check("nf_rd", {28'd0, rd_ex}, 9);
    check("nf_valid", {31'd0, valid_ex}, 1);

    clear_inputs();
    rd_id = 4'd15; rfld_id = 1;
    tick();
    clear_inputs();
    sa = 4'd15; use_a = 1; pa = 32'h40; rd_id = 4'd5; rfld_id = 1; memrd_id = 1;
    #1 check_ctl("nf_pc_src", 1'b1);
    tick();
    check("nf_pc_a", a_ex, 32'h40);

    clear_inputs();
    sd = 4'd5; use_d = 0; pd = 32'h1234; rd_id = 4'd5; rfld_id = 1;
    #1 check_ctl("nf_unused", 1'b1);
    tick();
    check("nf_unused_d", d_ex, 32'h1234);

    clear_inputs();
    sa = 4'd5; use_a = 1; pa = 32'h55; valid_id = 0;
    #1 check_ctl("nf_invalid", 1'b1);
    tick();
    check("nf_invalid_a", a_ex, 32'h55);
    check("nf_invalid_valid", {31'd0, valid_ex}, 0);

    clear_inputs();
    rd_id = 4'd6; rfld_id = 1;
    tick();
    clear_inputs();
    sb = 4'd6; use_b = 1;
    tick();
    #1 check_ctl("pre_reset_stall", 1'b0);
`endif

    // reset in the middle of a stall
    #1 rst = 1'b1;
    #1 check_regs_zero("mid_reset");
    check_ctl("mid_reset", 1'b1);
    tick();
    rst = 1'b0;
    clear_inputs();
    sa = 4'd7; use_a = 1; sb = 4'd6; use_b = 1; pa = 32'h70; pb = 32'h66; rd_id = 4'd1; rfld_id = 1;
    #1 check_ctl("post_reset", 1'b1);
    tick();
    check("post_reset_a", a_ex, 32'h70);
    check("post_reset_b", b_ex, 32'h66);
    check("post_reset_rd", {28'd0, rd_ex}, 1);

    // randomized run from a clean reset
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rd = 0; m_rfld = 0; m_memrd = 0; m_valid = 0; rem = 0;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      eff = 0;
      if (valid_id) begin
        eff = model_need(sa, use_a);
        if (model_need(sb, use_b) > eff) eff = model_need(sb, use_b);
        if (model_need(sd, use_d) > eff) eff = model_need(sd, use_d);
      end
      if (rem > eff) eff = rem;
      exp_stall = (eff > 0);
      ea = model_val(sa, use_a, pa);
      eb = model_val(sb, use_b, pb);
      ed = model_val(sd, use_d, pd);
      #1 check_ctl("rand", !exp_stall);
      tick();
      if (exp_stall) begin
        rem = eff - 1;
        m_rd = 0; m_rfld = 0; m_memrd = 0; m_valid = 0;
      end else begin
        rem = 0;
        m_rd = rd_id; m_rfld = rfld_id; m_memrd = memrd_id; m_valid = valid_id;
        check("rand_a", a_ex, ea);
        check("rand_b", b_ex, eb);
        check("rand_d", d_ex, ed);
      end
      check("rand_rd", {28'd0, rd_ex}, {28'd0, m_rd});
      check("rand_rfld", {31'd0, rfld_ex}, {31'd0, m_rfld});
      check("rand_memrd", {31'd0, memrd_ex}, {31'd0, m_memrd});
      check("rand_valid", {31'd0, valid_ex}, {31'd0, m_valid});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
